dmem_arbiter: RTL and testbench



---
 rtl/riscv_pkg.sv | 29 ++
 rtl/rr_arb2.sv | 19 +
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the core datapath; data-memory access selectors and
// data-memory arbiter state/ownership types.
package riscv_pkg;

   typedef enum logic [1:0] {
      Read     = 2'd0,
      Write    = 2'd1,
      NoAccess = 2'd2
   } DataMem_sel_e;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_DBG  = 1'b1
   } dmem_owner_e;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RESP   = 2'd2
   } dmem_arb_state_e;

   localparam int DMEM_BYTES_DEFAULT = 40;

   // 33-bit sum so addresses near the top of the 32-bit space cannot wrap into range.
   function automatic logic dmem_out_of_range(input logic [31:0] addr, input int unsigned bytes);
      return ({1'b0, addr} + 33'd3) >= 33'(bytes);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that did not own the previous transaction.
module rr_arb2
   import riscv_pkg::*;
(
   input  logic [1:0]  req,
   input  dmem_owner_e last_owner,
   input  logic        en,
   output logic [1:0]  gnt
);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         assign gnt[gi] = en & req[gi] &
                          (~req[1 - gi] | (logic'(last_owner) != 1'(gi)));
      end
   endgenerate

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data memory between the pipeline MEM stage and
// the debug/loader port: one 32-bit access per grant, registered response.
module dmem_arbiter
   import riscv_pkg::*;
#(
   parameter int DMEM_BYTES = DMEM_BYTES_DEFAULT
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         core_req,
   input  DataMem_sel_e core_rw,
   input  logic [31:0]  core_addr,
   input  logic [31:0]  core_wdata,
   output logic         core_gnt,
   output logic         core_rvalid,
   output logic [31:0]  core_rdata,
   output logic         core_err,
   output logic         core_stall,
   input  logic         dbg_req,
   input  DataMem_sel_e dbg_rw,
   input  logic [31:0]  dbg_addr,
   input  logic [31:0]  dbg_wdata,
   output logic         dbg_gnt,
   output logic         dbg_rvalid,
   output logic [31:0]  dbg_rdata,
   output logic         dbg_err,
   output DataMem_sel_e mem_rw,
   output logic [31:0]  mem_addr,
   output logic [31:0]  mem_wdata,
   input  logic [31:0]  mem_rdata
);

   dmem_arb_state_e state_reg;
   dmem_owner_e     last_owner_reg;
   dmem_owner_e     owner_reg;
   DataMem_sel_e    rw_reg;
   logic [31:0]     addr_reg;
   logic [31:0]     wdata_reg;
   logic            err_reg;
   logic [31:0]     rdata_reg;

   logic [1:0]      gnt;
   logic            arb_en;
   dmem_owner_e     win_owner;
   DataMem_sel_e    win_rw;
   logic [31:0]     win_addr;
   logic [31:0]     win_wdata;
   logic            resp_valid;

   // Grants are suppressed during reset so no transaction can start on that edge.
   assign arb_en = (state_reg == ARB_IDLE) && !rst;

   rr_arb2 u_rr_arb2 (
      .req        ({dbg_req, core_req}),
      .last_owner (last_owner_reg),
      .en         (arb_en),
      .gnt        (gnt)
   );

   assign win_owner = gnt[1] ? OWN_DBG : OWN_CORE;
   assign win_rw    = gnt[1] ? dbg_rw    : core_rw;
   assign win_addr  = gnt[1] ? dbg_addr  : core_addr;
   assign win_wdata = gnt[1] ? dbg_wdata : core_wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ARB_IDLE;
         last_owner_reg <= OWN_DBG;
         owner_reg      <= OWN_CORE;
         rw_reg         <= Read;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         err_reg        <= 1'b0;
         rdata_reg      <= '0;
      end else begin
         case (state_reg)
            ARB_IDLE: begin
               if (|gnt) begin
                  owner_reg      <= win_owner;
                  last_owner_reg <= win_owner;
                  rw_reg         <= win_rw;
                  addr_reg       <= win_addr;
                  wdata_reg      <= win_wdata;
                  err_reg        <= dmem_out_of_range(win_addr, DMEM_BYTES);
                  state_reg      <= ARB_ACCESS;
               end
            end
            ARB_ACCESS: begin
               rdata_reg <= (rw_reg == Read && !err_reg) ? mem_rdata : '0;
               state_reg <= ARB_RESP;
            end
            ARB_RESP: state_reg <= ARB_IDLE;
            default:  state_reg <= ARB_IDLE;
         endcase
      end
   end

   assign core_gnt  = gnt[0];
   assign dbg_gnt   = gnt[1];

   // The latched address/data double as the memory bus, so they hold between accesses.
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign mem_rw    = (state_reg == ARB_ACCESS && !err_reg && !rst) ? rw_reg : NoAccess;

   assign resp_valid  = (state_reg == ARB_RESP) && !rst;
   assign core_rvalid = resp_valid && (owner_reg == OWN_CORE);
   assign dbg_rvalid  = resp_valid && (owner_reg == OWN_DBG);
   assign core_rdata  = core_rvalid ? rdata_reg : '0;
   assign dbg_rdata   = dbg_rvalid  ? rdata_reg : '0;
   assign core_err    = core_rvalid && err_reg;
   assign dbg_err     = dbg_rvalid  && err_reg;
   assign core_stall  = core_req && !core_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios, then random two-port traffic
// against a transaction-level model with its own shadow memory.
module tb_dmem_arbiter;
   import riscv_pkg::*;

   localparam int NB = 40;

   logic         clk = 1'b0;
   logic         rst;
   logic         core_req, dbg_req;
   DataMem_sel_e core_rw, dbg_rw;
   logic [31:0]  core_addr, core_wdata, dbg_addr, dbg_wdata;
   logic         core_gnt, core_rvalid, core_err, core_stall;
   logic         dbg_gnt, dbg_rvalid, dbg_err;
   logic [31:0]  core_rdata, dbg_rdata;
   DataMem_sel_e mem_rw;
   logic [31:0]  mem_addr, mem_wdata, mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] env_mem [NB];
   logic [7:0] ref_mem [NB];
   logic       env_init;

   always #5 clk = ~clk;

   dmem_arbiter #(.DMEM_BYTES(NB)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_rw(core_rw), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .core_err(core_err), .core_stall(core_stall),
      .dbg_req(dbg_req), .dbg_rw(dbg_rw), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
      .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Memory array seen by the DUT; combinational read, write at the clock edge.
   always @(posedge clk) begin
      if (env_init) begin
         for (int i = 0; i < NB; i++) env_mem[i] <= 8'(i);
      end else if (mem_rw == Write && ({1'b0, mem_addr} + 33'd3) < 33'(NB)) begin
         for (int k = 0; k < 4; k++) env_mem[int'(mem_addr) + k] <= mem_wdata[8*k +: 8];
      end
   end

   always_comb begin
      mem_rdata = '0;
      if (({1'b0, mem_addr} + 33'd3) < 33'(NB))
         for (int k = 0; k < 4; k++) mem_rdata[8*k +: 8] = env_mem[int'(mem_addr) + k];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit oor(input logic [31:0] a);
      return (64'(a) + 64'd3) >= 64'(NB);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      logic [31:0] v;
      for (int k = 0; k < 4; k++) v[8*k +: 8] = ref_mem[int'(a) + k];
      return v;
   endfunction

   task automatic ref_wr(input logic [31:0] a, input logic [31:0] d);
      for (int k = 0; k < 4; k++) ref_mem[int'(a) + k] = d[8*k +: 8];
   endtask

   task automatic ref_init();
      for (int i = 0; i < NB; i++) ref_mem[i] = 8'(i);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut(input bit reload);
      rst = 1'b1;
      env_init = reload;
      core_req = 1'b0;
      dbg_req = 1'b0;
      @(negedge clk);
      check("rst_gnt", {30'd0, core_gnt, dbg_gnt}, 32'd0);
      check("rst_mem_rw", 32'(mem_rw), 32'(NoAccess));
      next_cycle();
      rst = 1'b0;
      env_init = 1'b0;
      if (reload) ref_init();
   endtask

   task automatic compare_mem(input string tag);
      for (int w = 0; w < NB / 4; w++) begin
         logic [31:0] got;
         for (int k = 0; k < 4; k++) got[8*k +: 8] = env_mem[4*w + k];
         check(tag, got, ref_rd(32'(4*w)));
      end
   endtask

   // One full transaction from an idle FSM; called at posedge+1, returns at posedge+1.
   task automatic txn(input bit is_dbg, input DataMem_sel_e rw, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit exp_err);
      if (is_dbg) begin
         dbg_req = 1'b1; dbg_rw = rw; dbg_addr = addr; dbg_wdata = wdata;
      end else begin
         core_req = 1'b1; core_rw = rw; core_addr = addr; core_wdata = wdata;
      end
      @(negedge clk);
      check("txn_gnt", {31'd0, is_dbg ? dbg_gnt : core_gnt}, 32'd1);
      if (!is_dbg) check("txn_stall0", {31'd0, core_stall}, 32'd1);
      next_cycle();
      @(negedge clk);
      check("txn_mem_rw", 32'(mem_rw), 32'(exp_err ? NoAccess : rw));
      check("txn_gnt_busy", {30'd0, core_gnt, dbg_gnt}, 32'd0);
      if (!is_dbg) check("txn_stall1", {31'd0, core_stall}, 32'd1);
      next_cycle();
      @(negedge clk);
      check("txn_rvalid", {30'd0, core_rvalid, dbg_rvalid}, is_dbg ? 32'd1 : 32'd2);
      check("txn_rdata", is_dbg ? dbg_rdata : core_rdata, exp_rdata);
      check("txn_err", {31'd0, is_dbg ? dbg_err : core_err}, {31'd0, exp_err});
      if (!is_dbg) check("txn_stall2", {31'd0, core_stall}, 32'd0);
      $display("txn %s %s addr=%h wdata=%h rdata=%h err=%0d", is_dbg ? "dbg " : "core",
               rw == Write ? "W" : "R", addr, wdata,
               is_dbg ? dbg_rdata : core_rdata, is_dbg ? dbg_err : core_err);
      next_cycle();
      core_req = 1'b0;
      dbg_req = 1'b0;
   endtask

   // Random-phase model state
   int           next_free, acc_cyc, resp_cyc;
   bit           m_last, r_owner, r_err, cg_seen, dg_seen;
   logic [31:0]  r_data;
   DataMem_sel_e acc_rw;

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(3) == 0) return 32'hFFFF_FFF8 + 32'($urandom_range(7));
      return 32'($urandom_range(NB));
   endfunction

   initial begin
      core_req = 1'b0; core_rw = Read; core_addr = '0; core_wdata = '0;
      dbg_req = 1'b0;  dbg_rw = Read;  dbg_addr = '0;  dbg_wdata = '0;
      rst = 1'b1;
      env_init = 1'b1;
      next_cycle();
      reset_dut(1'b1);

      @(negedge clk);
      check("rst_rvalid", {30'd0, core_rvalid, dbg_rvalid}, 32'd0);
      check("rst_err", {30'd0, core_err, dbg_err}, 32'd0);
      check("rst_core_rdata", core_rdata, 32'd0);
      check("rst_dbg_rdata", dbg_rdata, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_idle_rw", 32'(mem_rw), 32'(NoAccess));
      next_cycle();

      txn(1'b0, Read,  32'd4,  32'd0, 32'h0706_0504, 1'b0);
      txn(1'b1, Write, 32'd8,  32'hDEAD_BEEF, 32'd0, 1'b0);
      ref_wr(32'd8, 32'hDEAD_BEEF);
      txn(1'b0, Read,  32'd8,  32'd0, 32'hDEAD_BEEF, 1'b0);
      txn(1'b0, Read,  32'd36, 32'd0, 32'h2726_2524, 1'b0);
      txn(1'b0, Read,  32'd37, 32'd0, 32'd0, 1'b1);
      txn(1'b1, Write, 32'hFFFF_FFFE, 32'h55AA_55AA, 32'd0, 1'b1);
      txn(1'b0, Write, 32'd37, 32'h1234_5678, 32'd0, 1'b1);
      compare_mem("mem_after_directed");

      // Debug request raised and withdrawn during a core access
      core_req = 1'b1; core_rw = Read; core_addr = 32'd12;
      @(negedge clk);
      check("wd_core_gnt", {31'd0, core_gnt}, 32'd1);
      next_cycle();
      dbg_req = 1'b1; dbg_rw = Write; dbg_addr = 32'd12; dbg_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      check("wd_dbg_gnt_a", {31'd0, dbg_gnt}, 32'd0);
      check("wd_mem_rw", 32'(mem_rw), 32'(Read));
      next_cycle();
      dbg_req = 1'b0;
      @(negedge clk);
      check("wd_core_rdata", core_rdata, 32'h0F0E_0D0C);
      check("wd_dbg_gnt_b", {31'd0, dbg_gnt}, 32'd0);
      next_cycle();
      core_req = 1'b0;
      @(negedge clk);
      check("wd_idle_rw", 32'(mem_rw), 32'(NoAccess));
      check("wd_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
      next_cycle();
      compare_mem("mem_after_withdraw");

      // Reset arriving in the access cycle of a write
      dbg_req = 1'b1; dbg_rw = Write; dbg_addr = 32'd0; dbg_wdata = 32'h1122_3344;
      @(negedge clk);
      check("rw_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
      next_cycle();
      dbg_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rw_mem_rw", 32'(mem_rw), 32'(NoAccess));
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("rw_rvalid", {30'd0, core_rvalid, dbg_rvalid}, 32'd0);
      check("rw_mem_addr", mem_addr, 32'd0);
      check("rw_mem_wdata", mem_wdata, 32'd0);
      next_cycle();
      txn(1'b0, Read, 32'd0, 32'd0, 32'h0302_0100, 1'b0);

      // Both ports requesting from reset: core first, then alternating every 3 cycles
      reset_dut(1'b0);
      core_req = 1'b1; core_rw = Read; core_addr = 32'd0;
      dbg_req = 1'b1;  dbg_rw = Read;  dbg_addr = 32'd4;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         check("tie_core_gnt", {31'd0, core_gnt}, {31'd0, c % 3 == 0 && (c / 3) % 2 == 0});
         check("tie_dbg_gnt", {31'd0, dbg_gnt}, {31'd0, c % 3 == 0 && (c / 3) % 2 == 1});
         if (core_gnt || dbg_gnt) $display("tie grant cycle=%0d to %s", c, core_gnt ? "core" : "dbg");
         next_cycle();
      end
      core_req = 1'b0;
      dbg_req = 1'b0;

      // Random traffic against the transaction-level model
      reset_dut(1'b1);
      next_free = 0; acc_cyc = -1; resp_cyc = -1;
      m_last = 1'b1; r_owner = 1'b0; r_err = 1'b0; r_data = '0; acc_rw = NoAccess;
      cg_seen = 1'b0; dg_seen = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         bit          e_crv, e_drv, e_cg, e_dg, win;
         logic [31:0] e_rdata, a, wd;
         DataMem_sel_e e_mrw, rw;

         if (core_req && !cg_seen) begin
            if ($urandom_range(7) == 0) core_req = 1'b0;
         end else if ($urandom_range(1) == 1) begin
            core_req = 1'b1; core_rw = $urandom_range(1) == 1 ? Write : Read;
            core_addr = rand_addr(); core_wdata = $urandom;
         end else core_req = 1'b0;
         if (dbg_req && !dg_seen) begin
            if ($urandom_range(7) == 0) dbg_req = 1'b0;
         end else if ($urandom_range(1) == 1) begin
            dbg_req = 1'b1; dbg_rw = $urandom_range(1) == 1 ? Write : Read;
            dbg_addr = rand_addr(); dbg_wdata = $urandom;
         end else dbg_req = 1'b0;

         @(negedge clk);
         e_mrw   = (cyc == acc_cyc) ? acc_rw : NoAccess;
         e_crv   = (cyc == resp_cyc) && !r_owner;
         e_drv   = (cyc == resp_cyc) && r_owner;
         e_rdata = r_data;
         e_cg = 1'b0;
         e_dg = 1'b0;
         if (cyc >= next_free && (core_req || dbg_req)) begin
            win  = (core_req && dbg_req) ? !m_last : dbg_req;
            rw   = win ? dbg_rw : core_rw;
            a    = win ? dbg_addr : core_addr;
            wd   = win ? dbg_wdata : core_wdata;
            e_cg = !win;
            e_dg = win;
            r_owner = win;
            r_err   = oor(a);
            r_data  = (rw == Read && !r_err) ? ref_rd(a) : 32'd0;
            if (rw == Write && !r_err) ref_wr(a, wd);
            acc_rw    = r_err ? NoAccess : rw;
            acc_cyc   = cyc + 1;
            resp_cyc  = cyc + 2;
            next_free = cyc + 3;
            m_last    = win;
            $display("rnd cyc=%0d %s %s addr=%h wdata=%h exp_rdata=%h exp_err=%0d", cyc,
                     win ? "dbg " : "core", rw == Write ? "W" : "R", a, wd, r_data, r_err);
         end
         check("rnd_core_gnt", {31'd0, core_gnt}, {31'd0, e_cg});
         check("rnd_dbg_gnt", {31'd0, dbg_gnt}, {31'd0, e_dg});
         check("rnd_mem_rw", 32'(mem_rw), 32'(e_mrw));
         check("rnd_core_rvalid", {31'd0, core_rvalid}, {31'd0, e_crv});
         check("rnd_dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, e_drv});
         check("rnd_core_rdata", core_rdata, e_crv ? e_rdata : 32'd0);
         check("rnd_dbg_rdata", dbg_rdata, e_drv ? e_rdata : 32'd0);
         check("rnd_core_err", {31'd0, core_err}, {31'd0, e_crv && r_err && !e_cg && !e_dg});
         check("rnd_dbg_err", {31'd0, dbg_err}, {31'd0, e_drv && r_err && !e_cg && !e_dg});
         check("rnd_core_stall", {31'd0, core_stall}, {31'd0, core_req && !e_crv});
         cg_seen = core_gnt;
         dg_seen = dbg_gnt;
         next_cycle();
      end
      core_req = 1'b0;
      dbg_req = 1'b0;
      repeat (3) next_cycle();
      compare_mem("mem_after_random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
